// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN inference-engine control path.
//   ctrl_state_t   : sequencer states (load byte, shift pixels, start core, compute, transmit)
//   NUM_BYTES      : bytes per image
//   NUM_PIXELS     : input units per image (one bit per pixel)
//   ADDR_W         : input-unit RAM address width
//   DIGIT_W        : classification result width
//   ASCII_ZERO     : ASCII code of '0'
package snn_pkg;

  localparam int unsigned NUM_BYTES  = 98;
  localparam int unsigned NUM_PIXELS = NUM_BYTES * 8;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned DIGIT_W    = 4;
  localparam logic [BYTE_W-1:0] ASCII_ZERO = 8'h30;

  typedef enum logic [2:0] {
    LOAD,
    SHIFT,
    START,
    COMPUTE,
    TX
  } ctrl_state_t;

  // ASCII character for a digit; values above 9 pass through unchecked.
  function automatic logic [BYTE_W-1:0] digit_to_ascii(input logic [DIGIT_W-1:0] digit);
    return ASCII_ZERO + BYTE_W'(digit);
  endfunction

endpackage

// File: rtl/snn_byte_unpacker.sv
// Receive-side byte holding register and LSB-first bit unpacker.
//   clk, rst_n : clock, synchronous active-low reset
//   rx_rdy     : one-cycle pulse, rx_data valid
//   rx_data    : received byte
//   byte_take  : sequencer consumes the held byte into the shift register
//   bit_shift  : advance the shift register by one pixel
//   byte_vld   : a byte is waiting in the holding register
//   bit_out    : current pixel bit (shift register LSB)
//   bit_last   : current pixel is the eighth of its byte
//   overrun    : sticky, a received byte was dropped
module snn_byte_unpacker
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              byte_take,
  input  logic              bit_shift,
  output logic              byte_vld,
  output logic              bit_out,
  output logic              bit_last,
  output logic              overrun
);

  logic [BYTE_W-1:0] hold;
  logic              hold_vld;
  logic [BYTE_W-1:0] shreg;
  logic [2:0]        bit_cnt;

  // Holding register: a byte arriving while the previous one is still
  // unconsumed is dropped; a consume in the same cycle frees the slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold     <= '0;
      hold_vld <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (rx_rdy) begin
        if (hold_vld && !byte_take) begin
          overrun <= 1'b1;
        end else begin
          hold     <= rx_data;
          hold_vld <= 1'b1;
        end
      end else if (byte_take) begin
        hold_vld <= 1'b0;
      end
    end
  end

  // Shift register and bit counter, LSB leaves first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (byte_take) begin
      shreg   <= hold;
      bit_cnt <= '0;
    end else if (bit_shift) begin
      shreg   <= {1'b0, shreg[BYTE_W-1:1]};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign byte_vld = hold_vld;
  assign bit_out  = shreg[0];
  assign bit_last = (bit_cnt == 3'd7);

endmodule

// File: rtl/snn_ctrl.sv
// Top-level sequencer: unpacks a UART byte stream into the input-unit RAM,
// starts snn_core, waits for its result and sends it back as an ASCII digit.
//   clk, rst_n : clock, synchronous active-low reset
//   rx_rdy     : one-cycle pulse, rx_data valid
//   rx_data    : received byte, bit0 = lowest pixel address
//   core_addr  : snn_core input-unit address, routed to the RAM in COMPUTE
//   ram_addr   : input-unit RAM address
//   ram_we     : input-unit RAM write enable
//   ram_d      : input-unit RAM write data
//   snn_start  : one-cycle start pulse to snn_core
//   snn_done   : one-cycle done pulse from snn_core
//   snn_digit  : classification result, valid with snn_done
//   tx_rdy     : transmitter able to accept a byte
//   tx_start   : one-cycle pulse, send tx_data
//   tx_data    : ASCII '0' + digit
//   led        : last classified digit
//   busy       : low only when idle at the start of an image
//   overrun    : sticky, a received byte was dropped
module snn_ctrl
  import snn_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_rdy,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic [ADDR_W-1:0]  core_addr,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_we,
  output logic               ram_d,
  output logic               snn_start,
  input  logic               snn_done,
  input  logic [DIGIT_W-1:0] snn_digit,
  input  logic               tx_rdy,
  output logic               tx_start,
  output logic [BYTE_W-1:0]  tx_data,
  output logic [DIGIT_W-1:0] led,
  output logic               busy,
  output logic               overrun
);

  ctrl_state_t         state;
  logic [ADDR_W-1:0]   pix_cnt;
  logic [DIGIT_W-1:0]  dig;
  logic                byte_vld;
  logic                byte_take;
  logic                bit_shift;
  logic                bit_out;
  logic                bit_last;
  logic                pix_last;

  assign byte_take = (state == LOAD) && byte_vld;
  assign bit_shift = (state == SHIFT);
  assign pix_last  = (pix_cnt == ADDR_W'(NUM_PIXELS - 1));

  snn_byte_unpacker u_unpacker (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .byte_take (byte_take),
    .bit_shift (bit_shift),
    .byte_vld  (byte_vld),
    .bit_out   (bit_out),
    .bit_last  (bit_last),
    .overrun   (overrun)
  );

  // Sequencer; ram_we and snn_start are registered alongside the state
  // they belong to, so they are high exactly in SHIFT and START.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOAD;
      pix_cnt   <= '0;
      dig       <= '0;
      led       <= '0;
      tx_data   <= '0;
      ram_we    <= 1'b0;
      snn_start <= 1'b0;
      tx_start  <= 1'b0;
    end else begin
      ram_we    <= 1'b0;
      snn_start <= 1'b0;
      tx_start  <= 1'b0;
      unique case (state)
        LOAD: begin
          if (byte_vld) begin
            state  <= SHIFT;
            ram_we <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_last) begin
            if (pix_last) begin
              pix_cnt   <= '0;
              state     <= START;
              snn_start <= 1'b1;
            end else begin
              pix_cnt <= pix_cnt + ADDR_W'(1);
              state   <= LOAD;
            end
          end else begin
            pix_cnt <= pix_cnt + ADDR_W'(1);
            ram_we  <= 1'b1;
          end
        end
        START: begin
          state <= COMPUTE;
        end
        COMPUTE: begin
          if (snn_done) begin
            dig   <= snn_digit;
            led   <= snn_digit;
            state <= TX;
          end
        end
        TX: begin
          if (tx_rdy) begin
            tx_start <= 1'b1;
            tx_data  <= digit_to_ascii(dig);
            state    <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // The core owns the RAM address only while it computes.
  assign ram_addr = (state == COMPUTE) ? core_addr : pix_cnt;
  assign ram_d    = bit_out;
  assign busy     = !((state == LOAD) && (pix_cnt == '0));

endmodule

// File: tb/tb_snn_ctrl.sv
module tb_snn_ctrl;
  import snn_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              d;
  } wr_t;

  logic               clk;
  logic               rst_n;
  logic               rx_rdy;
  logic [BYTE_W-1:0]  rx_data;
  logic [ADDR_W-1:0]  core_addr;
  logic [ADDR_W-1:0]  ram_addr;
  logic               ram_we;
  logic               ram_d;
  logic               snn_start;
  logic               snn_done;
  logic [DIGIT_W-1:0] snn_digit;
  logic               tx_rdy;
  logic               tx_start;
  logic [BYTE_W-1:0]  tx_data;
  logic [DIGIT_W-1:0] led;
  logic               busy;
  logic               overrun;

  int vectors;
  int miscompares;
  int cyc;
  int start_cnt;
  int tx_cnt;
  int wr_cnt;
  int last_we_cyc;
  logic [ADDR_W-1:0] last_we_addr;
  logic [BYTE_W-1:0] last_tx_data;
  int exp_pix;
  wr_t exp_q[$];

  snn_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .core_addr (core_addr),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_d     (ram_d),
    .snn_start (snn_start),
    .snn_done  (snn_done),
    .snn_digit (snn_digit),
    .tx_rdy    (tx_rdy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .led       (led),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: every RAM write must match the next expected pixel.
  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (ram_we) begin
          vectors++;
          wr_cnt++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL ram_write unexpected: addr=%0d d=%0b", ram_addr, ram_d);
          end else begin
            e = exp_q.pop_front();
            if (ram_addr !== e.addr || ram_d !== e.d) begin
              miscompares++;
              $display("FAIL ram_write: got addr=%0d d=%0b, expected addr=%0d d=%0b",
                       ram_addr, ram_d, e.addr, e.d);
            end
          end
          last_we_cyc  = cyc;
          last_we_addr = ram_addr;
        end
        if (snn_start) begin
          vectors++;
          start_cnt++;
          if (cyc != last_we_cyc + 1 || last_we_addr !== ADDR_W'(NUM_PIXELS - 1)) begin
            miscompares++;
            $display("FAIL start_timing: start at cycle %0d, last write cycle %0d addr %0d, expected write of addr %0d one cycle earlier",
                     cyc, last_we_cyc, last_we_addr, NUM_PIXELS - 1);
          end
        end
        if (tx_start) begin
          tx_cnt++;
          last_tx_data = tx_data;
        end
      end
    end
  endtask

  // Caller is just after a posedge; byte is sampled at the next posedge.
  task automatic pulse_rx(input logic [7:0] b, input bit expect_written);
    rx_rdy  = 1'b1;
    rx_data = b;
    if (expect_written) begin
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(wr_t'{addr: ADDR_W'(exp_pix), d: b[i]});
        exp_pix = (exp_pix == int'(NUM_PIXELS) - 1) ? 0 : exp_pix + 1;
      end
    end
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
  endtask

  task automatic send_spaced(input int n, input bit use_a5);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      pulse_rx(use_a5 ? 8'hA5 : 8'($urandom_range(0, 255)), 1'b1);
      repeat (18) @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (ram_we !== 1'b0 || snn_start !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 ||
        led !== 4'h0 || overrun !== 1'b0 || busy !== 1'b0 || ram_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_state: we=%0b start=%0b txs=%0b txd=%h led=%0d ovr=%0b busy=%0b addr=%0d, expected all zero",
               ram_we, snn_start, tx_start, tx_data, led, overrun, busy, ram_addr);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_image_a5();
    int sb = start_cnt;
    int wb = wr_cnt;
    send_spaced(int'(NUM_BYTES), 1'b1);
    for (int i = 0; i < 200 && start_cnt == sb; i++) @(posedge clk);
    vectors++;
    if (start_cnt != sb + 1) begin
      miscompares++;
      $display("FAIL image_start_count: got %0d, expected 1", start_cnt - sb);
    end
    vectors++;
    if (wr_cnt - wb != int'(NUM_PIXELS)) begin
      miscompares++;
      $display("FAIL image_write_count: got %0d, expected %0d", wr_cnt - wb, NUM_PIXELS);
    end
    vectors++;
    if (overrun !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL image_clean: overrun=%0b pending=%0d, expected 0 and 0", overrun, exp_q.size());
    end
  endtask

  task automatic test_compute_mux();
    for (int i = 0; i < int'(NUM_PIXELS); i++) begin
      @(posedge clk);
      #1;
      core_addr = ADDR_W'(i);
      @(negedge clk);
      vectors++;
      if (ram_addr !== ADDR_W'(i) || ram_we !== 1'b0) begin
        miscompares++;
        $display("FAIL compute_mux: ram_addr=%0d we=%0b, expected %0d and 0", ram_addr, ram_we, i);
      end
    end
  endtask

  task automatic test_tx_wait();
    int tb = tx_cnt;
    tx_rdy = 1'b0;
    @(posedge clk);
    #1;
    snn_done  = 1'b1;
    snn_digit = 4'd7;
    @(posedge clk);
    #1;
    snn_done  = 1'b0;
    snn_digit = 4'd0;
    @(negedge clk);
    vectors++;
    if (led !== 4'd7) begin
      miscompares++;
      $display("FAIL led_digit: got %0d, expected 7", led);
    end
    core_addr = 10'd5;
    repeat (50) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (tx_cnt != tb || busy !== 1'b1 || ram_addr !== '0) begin
      miscompares++;
      $display("FAIL tx_hold: tx_starts=%0d busy=%0b ram_addr=%0d, expected 0, 1, 0", tx_cnt - tb, busy, ram_addr);
    end
    tx_rdy = 1'b1;
    for (int i = 0; i < 20 && tx_cnt == tb; i++) @(posedge clk);
    vectors++;
    if (tx_cnt != tb + 1 || last_tx_data !== 8'h37) begin
      miscompares++;
      $display("FAIL tx_send: tx_starts=%0d data=%h, expected 1 and 37", tx_cnt - tb, last_tx_data);
    end
    @(negedge clk);
    repeat (5) @(posedge clk);
    vectors++;
    if (tx_cnt != tb + 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_single_back_to_load: tx_starts=%0d busy=%0b, expected 1 and 0", tx_cnt - tb, busy);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    #1;
    pulse_rx(8'h3C, 1'b1);
    pulse_rx(8'hC3, 1'b1);
    repeat (30) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (overrun !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL back_to_back: overrun=%0b pending=%0d, expected 0 and 0", overrun, exp_q.size());
    end
  endtask

  task automatic test_overrun();
    @(posedge clk);
    #1;
    pulse_rx(8'h81, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    pulse_rx(8'h5A, 1'b1);
    @(posedge clk);
    #1;
    pulse_rx(8'hFF, 1'b0);
    @(negedge clk);
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_set: got %0b, expected 1", overrun);
    end
    repeat (40) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (overrun !== 1'b1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL overrun_sticky: overrun=%0b pending=%0d, expected 1 and 0", overrun, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_image();
    int sb;
    int wb;
    int tb;
    // 4 bytes of this image were sent by the previous two scenarios.
    send_spaced(36, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (overrun !== 1'b0 || led !== 4'd0 || busy !== 1'b0 || tx_data !== 8'h00 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mid_reset: overrun=%0b led=%0d busy=%0b txd=%h pending=%0d, expected all 0",
               overrun, led, busy, tx_data, exp_q.size());
    end
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_pix = 0;
    tb = tx_cnt;
    snn_done  = 1'b1;
    snn_digit = 4'd9;
    @(posedge clk);
    #1;
    snn_done  = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (tx_cnt != tb || led !== 4'd0) begin
      miscompares++;
      $display("FAIL done_in_load: tx_starts=%0d led=%0d, expected 0 and 0", tx_cnt - tb, led);
    end
    sb = start_cnt;
    wb = wr_cnt;
    send_spaced(int'(NUM_BYTES), 1'b0);
    for (int i = 0; i < 200 && start_cnt == sb; i++) @(posedge clk);
    vectors++;
    if (start_cnt != sb + 1 || wr_cnt - wb != int'(NUM_PIXELS) || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL fresh_image: starts=%0d writes=%0d pending=%0d, expected 1, %0d, 0",
               start_cnt - sb, wr_cnt - wb, exp_q.size(), NUM_PIXELS);
    end
    tb = tx_cnt;
    @(posedge clk);
    #1;
    snn_done  = 1'b1;
    snn_digit = 4'hC;
    @(posedge clk);
    #1;
    snn_done  = 1'b0;
    snn_digit = 4'd0;
    for (int i = 0; i < 20 && tx_cnt == tb; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    vectors++;
    if (tx_cnt != tb + 1 || last_tx_data !== 8'h3C || led !== 4'hC || start_cnt != sb + 1) begin
      miscompares++;
      $display("FAIL digit_passthrough: tx_starts=%0d data=%h led=%0d starts=%0d, expected 1, 3c, 12, 1",
               tx_cnt - tb, last_tx_data, led, start_cnt - sb);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    cyc          = 0;
    start_cnt    = 0;
    tx_cnt       = 0;
    wr_cnt       = 0;
    last_we_cyc  = -10;
    last_we_addr = '0;
    last_tx_data = '0;
    exp_pix      = 0;
    rst_n        = 1'b0;
    rx_rdy       = 1'b0;
    rx_data      = '0;
    core_addr    = 10'h155;
    snn_done     = 1'b0;
    snn_digit    = '0;
    tx_rdy       = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_image_a5();
    test_compute_mux();
    test_tx_wait();
    core_addr = 10'h3FF;
    test_back_to_back();
    test_overrun();
    test_reset_mid_image();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
